uart_rx: RTL and testbench

- 8N1 UART receiver for the nanoV top level, fed from the uart_rxd bidi input (uio_in[5]).
- Mirrors the existing uart_tx and uses the same CLK_HZ/BIT_RATE parameterisation.
- Holds one received byte plus sticky status flags, so the CPU can poll it over the memory-mapped UART data/status addresses.
- Consume handshake: uart_rx_read.

---
 rtl/uart_rx.sv | 156 +++++++++++++++
 tb/tb_uart_rx.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: samples each bit at its nominal centre, holds one byte
// and sticky status flags until the CPU consumes them with uart_rx_read.
module uart_rx #(
  parameter int unsigned CLK_HZ   = 12_000_000,
  parameter int unsigned BIT_RATE = 115_200
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       uart_rxd,
  input  logic       uart_rx_en,
  input  logic       uart_rx_read,
  output logic [7:0] uart_rx_data,
  output logic       uart_rx_valid,
  output logic       uart_rx_busy,
  output logic       uart_rx_frame_err,
  output logic       uart_rx_break,
  output logic       uart_rx_overrun
);

  localparam int unsigned CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
  localparam int unsigned HALF_BIT       = CYCLES_PER_BIT / 2;
  localparam int unsigned CntW           = $clog2(CYCLES_PER_BIT + 1);

  // START is entered one cycle after the start edge, so its terminal count is one short.
  localparam logic [CntW-1:0] HalfLast = CntW'(HALF_BIT - 1);
  localparam logic [CntW-1:0] BitLast  = CntW'(CYCLES_PER_BIT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StRecover
  } state_e;

  state_e          state_q;
  logic [1:0]      sync_q;
  logic            rxs;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      bit_idx_q;
  logic [7:0]      shift_q;
  logic [7:0]      data_q;
  logic            valid_q;
  logic            frame_err_q;
  logic            break_q;
  logic            overrun_q;

  assign rxs = sync_q[1];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= StIdle;
      sync_q      <= 2'b11;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      break_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], uart_rxd};

      // Clears first so that any flag set below in the same cycle wins.
      if (uart_rx_read) begin
        valid_q     <= 1'b0;
        frame_err_q <= 1'b0;
        break_q     <= 1'b0;
        overrun_q   <= 1'b0;
      end

      case (state_q)
        StIdle: begin
          cnt_q <= '0;
          if (uart_rx_en && !rxs) begin
            state_q <= StStart;
          end
        end

        StStart: begin
          cnt_q <= cnt_q + 1'b1;
          if (!uart_rx_en) begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end else if (cnt_q == HalfLast) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            state_q   <= rxs ? StIdle : StData;
          end
        end

        StData: begin
          cnt_q <= cnt_q + 1'b1;
          if (!uart_rx_en) begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end else if (cnt_q == BitLast) begin
            cnt_q     <= '0;
            shift_q   <= {rxs, shift_q[7:1]};
            bit_idx_q <= bit_idx_q + 1'b1;
            if (bit_idx_q == 3'd7) begin
              state_q <= StStop;
            end
          end
        end

        StStop: begin
          cnt_q <= cnt_q + 1'b1;
          if (!uart_rx_en) begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end else if (cnt_q == BitLast) begin
            cnt_q <= '0;
            if (rxs) begin
              // A read in this cycle frees the holding register for the new byte.
              if (!valid_q || uart_rx_read) begin
                data_q  <= shift_q;
                valid_q <= 1'b1;
              end else begin
                overrun_q <= 1'b1;
              end
              state_q <= StIdle;
            end else begin
              frame_err_q <= 1'b1;
              if (shift_q == 8'h00) begin
                break_q <= 1'b1;
              end
              state_q <= StRecover;
            end
          end
        end

        StRecover: begin
          cnt_q <= '0;
          if (rxs) begin
            state_q <= StIdle;
          end
        end

        default: begin
          state_q <= StIdle;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign uart_rx_data      = data_q;
  assign uart_rx_valid     = valid_q;
  assign uart_rx_busy      = (state_q != StIdle);
  assign uart_rx_frame_err = frame_err_q;
  assign uart_rx_break     = break_q;
  assign uart_rx_overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: table of frames plus hand-written timing, glitch, break,
// coincident-read, reset and enable-drop sequences; loaded bytes go via a scoreboard.
module tb_uart_rx;

  localparam int unsigned Cpb = 104;

  logic       clk = 1'b0;
  logic       resetn;
  logic       uart_rxd;
  logic       uart_rx_en;
  logic       uart_rx_read;
  logic [7:0] uart_rx_data;
  logic       uart_rx_valid;
  logic       uart_rx_busy;
  logic       uart_rx_frame_err;
  logic       uart_rx_break;
  logic       uart_rx_overrun;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] sb_q[$];

  uart_rx #(
    .CLK_HZ  (12_000_000),
    .BIT_RATE(115_200)
  ) dut (
    .clk              (clk),
    .resetn           (resetn),
    .uart_rxd         (uart_rxd),
    .uart_rx_en       (uart_rx_en),
    .uart_rx_read     (uart_rx_read),
    .uart_rx_data     (uart_rx_data),
    .uart_rx_valid    (uart_rx_valid),
    .uart_rx_busy     (uart_rx_busy),
    .uart_rx_frame_err(uart_rx_frame_err),
    .uart_rx_break    (uart_rx_break),
    .uart_rx_overrun  (uart_rx_overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       load;
    logic [7:0] e_data;
    logic       e_valid;
    logic       e_fe;
    logic       e_brk;
    logic       e_ovr;
    logic       rd;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1 uart_rxd = bits[i];
      repeat (Cpb - 1) @(posedge clk);
    end
    @(posedge clk);
    #1 uart_rxd = 1'b1;
    repeat (2 * Cpb) @(posedge clk);
  endtask

  task automatic pulse_read();
    @(posedge clk);
    #1 uart_rx_read = 1'b1;
    @(posedge clk);
    #1 uart_rx_read = 1'b0;
  endtask

  task automatic wait_busy(input string name);
    int k;
    k = 0;
    while (uart_rx_busy !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (uart_rx_busy !== 1'b1) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: busy never rose, got 0 expected 1", name);
    end
  endtask

  task automatic check_status(input string name, input logic [7:0] d, input logic v,
                              input logic fe, input logic brk, input logic ovr);
    @(negedge clk);
    check({name, "_data"}, 32'(uart_rx_data), 32'(d));
    check({name, "_flags"},
          32'({uart_rx_valid, uart_rx_frame_err, uart_rx_break, uart_rx_overrun}),
          32'({v, fe, brk, ovr}));
  endtask

  // Scoreboard: a load is a valid rise, or a new byte replacing a held one.
  logic       prev_valid = 1'b0;
  logic [7:0] prev_data  = 8'h00;
  always @(negedge clk) begin
    if (resetn === 1'b1 && uart_rx_valid === 1'b1 &&
        (prev_valid !== 1'b1 || uart_rx_data !== prev_data)) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sb_unexpected: got %0h expected none", uart_rx_data);
      end else begin
        check("sb_load", 32'(uart_rx_data), 32'(sb_q.pop_front()));
      end
    end
    prev_valid = uart_rx_valid;
    prev_data  = uart_rx_data;
  end

  initial begin
    int cnt;
    logic busy_gap;

    //          data  stop  load  e_data v  fe brk ovr rd
    vecs[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{8'h3C, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{8'h11, 1'b1, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{8'h22, 1'b1, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[4] = '{8'h33, 1'b1, 1'b1, 8'h33, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{8'h3C, 1'b0, 1'b0, 8'h33, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{8'h00, 1'b0, 1'b0, 8'h33, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{8'h55, 1'b1, 1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    resetn       = 1'b0;
    uart_rxd     = 1'b1;
    uart_rx_en   = 1'b1;
    uart_rx_read = 1'b0;
    repeat (4) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    check("reset_busy", 32'(uart_rx_busy), 32'd0);
    check_status("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      if (vecs[i].load) sb_q.push_back(vecs[i].data);
      send_frame(vecs[i].data, vecs[i].stop);
      check_status($sformatf("vec%0d", i), vecs[i].e_data, vecs[i].e_valid,
                   vecs[i].e_fe, vecs[i].e_brk, vecs[i].e_ovr);
      if (vecs[i].rd) begin
        pulse_read();
        check_status($sformatf("vec%0d_rd", i), vecs[i].e_data, 1'b0, 1'b0, 1'b0, 1'b0);
      end
    end

    // Valid rises 988 cycles after busy, busy stays high until then.
    sb_q.push_back(8'hA5);
    cnt      = 0;
    busy_gap = 1'b0;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        wait_busy("timing");
        while (uart_rx_valid !== 1'b1 && cnt < 2000) begin
          if (uart_rx_busy !== 1'b1) busy_gap = 1'b1;
          @(negedge clk);
          cnt++;
        end
        check("timing_valid_cycle", 32'(cnt), 32'd988);
        check("timing_busy_drop", 32'(uart_rx_busy), 32'd0);
        check("timing_busy_gap", 32'(busy_gap), 32'd0);
      end
    join
    check_status("timing", 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
    pulse_read();

    // 20-cycle glitch: false start, busy for 52 cycles.
    cnt = 0;
    fork
      begin
        @(posedge clk);
        #1 uart_rxd = 1'b0;
        repeat (20) @(posedge clk);
        #1 uart_rxd = 1'b1;
      end
      for (int k = 0; k < 300; k++) begin
        @(negedge clk);
        if (uart_rx_busy === 1'b1) cnt++;
      end
    join
    check("glitch_busy_len", 32'(cnt), 32'd52);
    check_status("glitch", 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
    sb_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    check_status("after_glitch", 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);
    pulse_read();

    // Long break: one error, cleared by read, no further events while held low.
    @(posedge clk);
    #1 uart_rxd = 1'b0;
    repeat (1500) @(posedge clk);
    check_status("break", 8'h3C, 1'b0, 1'b1, 1'b1, 1'b0);
    pulse_read();
    repeat (22400) @(posedge clk);
    check_status("break_held", 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    check("break_recover_busy", 32'(uart_rx_busy), 32'd1);
    #1 uart_rxd = 1'b1;
    repeat (Cpb) @(posedge clk);
    @(negedge clk);
    check("break_release_busy", 32'(uart_rx_busy), 32'd0);
    sb_q.push_back(8'h55);
    send_frame(8'h55, 1'b1);
    check_status("after_break", 8'h55, 1'b1, 1'b0, 1'b0, 1'b0);
    pulse_read();

    // Read coincident with the stop sample while a byte is held.
    sb_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    sb_q.push_back(8'h7E);
    fork
      send_frame(8'h7E, 1'b1);
      begin
        wait_busy("coincident");
        repeat (987) @(posedge clk);
        #1 uart_rx_read = 1'b1;
        @(posedge clk);
        #1 uart_rx_read = 1'b0;
      end
    join
    check_status("coincident", 8'h7E, 1'b1, 1'b0, 1'b0, 1'b0);
    pulse_read();

    // Reset during data bit 4 of 0xFF.
    fork
      send_frame(8'hFF, 1'b1);
      begin
        wait_busy("reset_mid");
        repeat (52 + 4 * Cpb + 50) @(posedge clk);
        #1 resetn = 1'b0;
        @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        check("reset_mid_busy", 32'(uart_rx_busy), 32'd0);
        check_status("reset_mid", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      end
    join
    check_status("reset_after", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    sb_q.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    check_status("after_reset", 8'h81, 1'b1, 1'b0, 1'b0, 1'b0);

    // Enable drop mid-frame with 0x81 still held: frame discarded, flags kept.
    fork
      send_frame(8'h5A, 1'b1);
      begin
        wait_busy("en_drop");
        repeat (350) @(posedge clk);
        #1 uart_rx_en = 1'b0;
        repeat (2) @(negedge clk);
        check("en_drop_busy", 32'(uart_rx_busy), 32'd0);
      end
    join
    #1 uart_rx_en = 1'b1;
    check_status("en_drop", 8'h81, 1'b1, 1'b0, 1'b0, 1'b0);
    pulse_read();
    check_status("final", 8'h81, 1'b0, 1'b0, 1'b0, 1'b0);
    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
